// File: rtl/hazard_pkg.sv
// Shared types and constants for the D-stage stall controller.
package hazard_pkg;

   localparam logic [1:0] TUSE_NONE = 2'd3;
   localparam logic [1:0] TNEW_JAL  = 2'd0;
   localparam logic [1:0] TNEW_ALU  = 2'd1;
   localparam logic [1:0] TNEW_LOAD = 2'd2;

   // One pending register write tracked in the shadow scoreboard
   typedef struct packed {
      logic [4:0] a3;
      logic [1:0] tnew;
   } sb_entry_t;

   // A source needs a value sooner than this entry can forward it.
   // src!=0 also keeps a3==0 entries (bubbles, non-writers) from matching.
   function automatic logic src_hit(input logic [4:0] src, input logic [1:0] tuse,
                                    input sb_entry_t e);
      return (src != 5'd0) && (tuse != TUSE_NONE) && (src == e.a3) && (tuse < e.tnew);
   endfunction

endpackage

// File: rtl/hazard_stall_unit_md_busy_counter.sv
// Busy tracker for the multi-cycle mult/div unit.
module md_busy_counter
   import hazard_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10,
   parameter int unsigned CNT_W       = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic is_div,
   output logic busy
);

   logic [CNT_W-1:0] cnt;

   // Reload on a new op in E (wins over decrement), otherwise count down to 0
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (start)
         cnt <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      else if (cnt != '0)
         cnt <= cnt - CNT_W'(1);
   end

   // The op sitting in E already occupies the unit
   assign busy = start | (cnt != '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// D-stage stall controller: shadow E/M write scoreboard plus mult/div busy.
module hazard_stall_unit
   import hazard_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10,
   parameter int unsigned CNT_W       = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] D_rs,
   input  logic [4:0] D_rt,
   input  logic [1:0] D_tuse_rs,
   input  logic [1:0] D_tuse_rt,
   input  logic [4:0] D_a3,
   input  logic [1:0] D_tnew,
   input  logic       D_md_start,
   input  logic       D_md_div,
   input  logic       D_md_use,
   output logic       stall,
   output logic       pc_en,
   output logic       d_en,
   output logic       e_clr,
   output logic       md_busy
);

   sb_entry_t e_q, m_q;
   logic      e_md, e_div;
   logic      rs_hz, rt_hz, md_hz;

   // Shadow pipeline: E takes D or a bubble, M ages E's Tnew by one (saturating)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_q   <= '0;
         m_q   <= '0;
         e_md  <= 1'b0;
         e_div <= 1'b0;
      end else begin
         if (stall) begin
            e_q   <= '0;
            e_md  <= 1'b0;
            e_div <= 1'b0;
         end else begin
            e_q.a3   <= D_a3;
            e_q.tnew <= D_tnew;
            e_md     <= D_md_start;
            e_div    <= D_md_div;
         end
         m_q.a3   <= e_q.a3;
         m_q.tnew <= (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
      end
   end

   md_busy_counter #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES),
      .CNT_W       (CNT_W)
   ) u_md (
      .clk    (clk),
      .reset  (reset),
      .start  (e_md),
      .is_div (e_div),
      .busy   (md_busy)
   );

   // Hazard decode is purely combinational from shadow state and D inputs
   always_comb begin
      rs_hz = src_hit(D_rs, D_tuse_rs, e_q) | src_hit(D_rs, D_tuse_rs, m_q);
      rt_hz = src_hit(D_rt, D_tuse_rt, e_q) | src_hit(D_rt, D_tuse_rt, m_q);
      md_hz = D_md_use & md_busy;
   end

   assign stall = rs_hz | rt_hz | md_hz;
   assign pc_en = ~stall;
   assign d_en  = ~stall;
   assign e_clr = stall;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Randomized + directed check of hazard_stall_unit against a timestamp model.
module tb_hazard_stall_unit;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] D_rs = '0, D_rt = '0, D_a3 = '0;
   logic [1:0] D_tuse_rs = 2'd3, D_tuse_rt = 2'd3, D_tnew = '0;
   logic       D_md_start = 1'b0, D_md_div = 1'b0, D_md_use = 1'b0;
   logic       stall, pc_en, d_en, e_clr, md_busy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   hazard_stall_unit dut (
      .clk        (clk),
      .reset      (reset),
      .D_rs       (D_rs),
      .D_rt       (D_rt),
      .D_tuse_rs  (D_tuse_rs),
      .D_tuse_rt  (D_tuse_rt),
      .D_a3       (D_a3),
      .D_tnew     (D_tnew),
      .D_md_start (D_md_start),
      .D_md_div   (D_md_div),
      .D_md_use   (D_md_use),
      .stall      (stall),
      .pc_en      (pc_en),
      .d_en       (d_en),
      .e_clr      (e_clr),
      .md_busy    (md_busy)
   );

   // Reference model: each in-flight writer carries the absolute cycle at
   // which its result becomes forwardable; the mult/div unit carries the
   // first cycle at which it is free again.
   typedef struct {
      int a3;
      int ready;
   } ent_t;

   ent_t me = '{0, 0};
   ent_t mm = '{0, 0};
   int   cyc = 0;
   int   md_free = 0;

   function automatic bit m_hit(input int src, input int tuse);
      if (src == 0 || tuse == 3) return 1'b0;
      return (me.a3 == src && cyc + tuse < me.ready) ||
             (mm.a3 == src && cyc + tuse < mm.ready);
   endfunction

   function automatic bit m_stall();
      return m_hit(int'(D_rs), int'(D_tuse_rs)) || m_hit(int'(D_rt), int'(D_tuse_rt)) ||
             (D_md_use && cyc < md_free);
   endfunction

   task automatic model_clear();
      me = '{0, 0};
      mm = '{0, 0};
      md_free = 0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock: check outputs mid-cycle, then advance the model at the edge
   task automatic tick(output bit obs);
      bit es;
      @(negedge clk);
      es = m_stall();
      chk("stall", stall, es);
      chk("pc_en", pc_en, !es);
      chk("d_en", d_en, !es);
      chk("e_clr", e_clr, es);
      chk("md_busy", md_busy, cyc < md_free);
      obs = stall;
      @(posedge clk);
      mm = me;
      if (es) me = '{0, 0};
      else begin
         me = '{int'(D_a3), cyc + 1 + int'(D_tnew)};
         if (D_md_start) md_free = cyc + 1 + (D_md_div ? 10 : 5) + 1;
      end
      cyc++;
      #1;
   endtask

   // Present one D instruction and hold it until it leaves D; ns = stall cycles seen
   task automatic issue(input int a3, input int tnew, input int rs, input int trs,
                        input int rt, input int trt, input bit ms, input bit md,
                        input bit mu, output int ns);
      bit s;
      D_a3 = 5'(a3); D_tnew = 2'(tnew);
      D_rs = 5'(rs); D_tuse_rs = 2'(trs);
      D_rt = 5'(rt); D_tuse_rt = 2'(trt);
      D_md_start = ms; D_md_div = md; D_md_use = mu;
      ns = 0;
      for (int k = 0; k < 16; k++) begin
         tick(s);
         if (!s) return;
         ns++;
      end
      chk("issue_timeout", 32'd1, 32'd0);
   endtask

   task automatic nop2();
      int ns;
      issue(0, 0, 0, 3, 0, 3, 0, 0, 0, ns);
      issue(0, 0, 0, 3, 0, 3, 0, 0, 0, ns);
   endtask

   initial begin
      int ns;
      bit s;

      // Reset state
      #12;
      chk("rst_stall", stall, 0);
      chk("rst_pc_en", pc_en, 1);
      chk("rst_d_en", d_en, 1);
      chk("rst_e_clr", e_clr, 0);
      chk("rst_md_busy", md_busy, 0);
      @(posedge clk);
      #1 reset = 1'b1;

      // Load-use: two bubbles
      issue(1, 2, 0, 3, 0, 3, 0, 0, 0, ns);
      issue(0, 0, 1, 0, 0, 3, 0, 0, 0, ns);
      chk("load_use_stalls", ns, 2);
      nop2();

      // ALU result in E, needed now vs. one cycle later
      issue(2, 1, 0, 3, 0, 3, 0, 0, 0, ns);
      issue(0, 0, 2, 0, 0, 3, 0, 0, 0, ns);
      chk("alu_use_t0", ns, 1);
      nop2();
      issue(2, 1, 0, 3, 0, 3, 0, 0, 0, ns);
      issue(0, 0, 2, 1, 0, 3, 0, 0, 0, ns);
      chk("alu_use_t1", ns, 0);
      nop2();

      // $0 and non-read sources never stall
      issue(0, 2, 0, 3, 0, 3, 0, 0, 0, ns);
      issue(0, 0, 0, 0, 0, 0, 0, 0, 0, ns);
      chk("reg0_stalls", ns, 0);
      issue(3, 2, 0, 3, 0, 3, 0, 0, 0, ns);
      issue(0, 0, 0, 3, 3, 3, 0, 0, 0, ns);
      chk("tuse3_stalls", ns, 0);
      nop2();

      // mult then mflo: busy for E cycle + 5
      issue(0, 1, 0, 3, 0, 3, 1, 0, 1, ns);
      chk("mult_issue", ns, 0);
      issue(4, 1, 0, 3, 0, 3, 0, 0, 1, ns);
      chk("mflo_stalls", ns, 6);

      // div back-to-back: second waits E cycle + 10
      issue(0, 1, 0, 3, 0, 3, 1, 1, 1, ns);
      chk("div1_issue", ns, 0);
      issue(0, 1, 0, 3, 0, 3, 1, 1, 1, ns);
      chk("div2_stalls", ns, 11);

      // Async reset mid-count drops busy and stall without an edge
      D_a3 = '0; D_rs = '0; D_rt = '0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3;
      D_md_start = 1'b0; D_md_div = 1'b0; D_md_use = 1'b1;
      tick(s);
      tick(s);
      #2 reset = 1'b0;
      #1;
      chk("midrst_md_busy", md_busy, 0);
      chk("midrst_stall", stall, 0);
      chk("midrst_pc_en", pc_en, 1);
      model_clear();
      @(posedge clk);
      #1 reset = 1'b1;
      tick(s);

      // Random traffic over a small register set to provoke hits
      s = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (!s) begin
            D_a3       = 5'($urandom_range(0, 3));
            D_tnew     = 2'($urandom_range(0, 2));
            D_rs       = 5'($urandom_range(0, 3));
            D_tuse_rs  = 2'($urandom_range(0, 3));
            D_rt       = 5'($urandom_range(0, 3));
            D_tuse_rt  = 2'($urandom_range(0, 3));
            D_md_start = ($urandom_range(0, 9) == 0);
            D_md_div   = 1'($urandom_range(0, 1));
            D_md_use   = D_md_start | ($urandom_range(0, 5) == 0);
         end
         tick(s);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall-side hazard controller for the 5-stage MIPS pipeline. It complements the forwarding selector, which picks bypass sources.
- Keeps its own E/M shadow scoreboard of pending register writes (destination, Tnew) and decides when the D stage must freeze because forwarding cannot yet supply a value.
- Also tracks the multi-cycle mult/div unit and stalls HI/LO accesses while that unit is busy.
- Sits beside the D/E pipeline registers and drives PC/D enables and the E-register flush.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu after issue from E.
- DIV_CYCLES, 10, busy cycles for div/divu after issue from E.
- CNT_W, 4, width of the busy counter; must hold DIV_CYCLES.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- D_rs  in  5  rs (A1) of the D-stage instruction.
- D_rt  in  5  rt (A2) of the D-stage instruction.
- D_tuse_rs  in  2  cycles until D needs rs: 0, 1, 2; 3 = not read.
- D_tuse_rt  in  2  same encoding for rt.
- D_a3  in  5  destination register of the D instruction; 0 = no write.
- D_tnew  in  2  cycles after entering E until the result is forwardable: jal=0, ALU/mfhi/mflo=1, load=2.
- D_md_start  in  1  D instruction is mult/multu/div/divu.
- D_md_div  in  1  qualifies D_md_start: 1 = div/divu.
- D_md_use  in  1  D instruction is mfhi/mflo/mthi/mtlo/mult/div.
- stall  out  1  D-stage hazard this cycle.
- pc_en  out  1  = ~stall.
- d_en  out  1  = ~stall; enable of the F/D register.
- e_clr  out  1  = stall; inserts a bubble into the D/E register.
- md_busy  out  1  mult/div unit occupied.

Behaviour:
- Reset (reset=0, async): all shadow regs, flags and counter go to 0. Outputs then read stall=0, pc_en=1, d_en=1, e_clr=0, md_busy=0.
- Shadow state: E_a3/E_tnew/E_md/E_div and M_a3/M_tnew.
- Each rising edge, E stage:
  - if stall, E_* <= 0 (bubble);
  - else E_a3 <= D_a3, E_tnew <= D_tnew, E_md <= D_md_start, E_div <= D_md_div.
- Each rising edge, M stage: M_a3 <= E_a3, M_tnew <= (E_tnew==0 ? 0 : E_tnew-1). This is saturating; no wrap below 0.
- W stage is never tracked: a W result always has Tnew=0 and is covered by forwarding.
- Register hazard, for src in {rs, rt} (combinational):
  - a source hits a stage if src!=0 && src==X_a3 && D_tuse_src < X_tnew, for X in {E, M};
  - TUSE=3 never stalls;
  - register 0 never stalls;
  - an X_a3==0 entry never matches.
- Busy counter:
  - on an edge with E_md=1, cnt <= (E_div ? DIV_CYCLES : MULT_CYCLES);
  - else if cnt!=0, cnt <= cnt-1.
- md_busy = E_md | (cnt!=0).
- md hazard = D_md_use & md_busy. A new mult/div in D therefore waits for the previous one to finish.
- stall = rs hazard | rt hazard | md hazard. Output is combinational from state plus D inputs, with no added latency.
- Simultaneous events: if E_md=1 while cnt!=0, the reload wins. A bubble inserted during stall carries no md flag and no a3.
- Mid-operation reset clears the counter immediately; md_busy falls with reset, not on the next edge.

Decomposition:
- Package hazard_pkg holds:
  - TUSE_NONE=2'd3;
  - TNEW_JAL=0, TNEW_ALU=1, TNEW_LOAD=2;
  - the scoreboard entry struct {a3[4:0], tnew[1:0]}.
- One natural sub-module: md_busy_counter (clk, reset, start, is_div, busy), holding the counter and the reload/decrement logic.

Test Plan:
- Load-use: lw $1 (D_a3=1, D_tnew=2) then beq-like D_rs=1, D_tuse_rs=0 -> stall=1 for 2 cycles, e_clr=1 each, then stall=0.
- ALU-use in E: addu $2 (tnew 1) then D_rs=2, tuse 0 -> stall=1 one cycle. Same case with tuse 1 -> stall=0 throughout.
- $0 and no-read: D_a3=0 writer followed by D_rs=0, tuse 0 -> stall never asserts. D_tuse_rt=3 with rt matching E_a3 (tnew 2) -> no stall.
- Mult then mflo: D_md_start (mult) then D_md_use -> md_busy 1 for 1+5 cycles, stall=1 over the same window; mflo proceeds on the cycle md_busy drops.
- Div back-to-back: div followed by div -> second stalls for 11 cycles. Then pulse reset low mid-count -> md_busy=0 and stall=0 immediately, asynchronously.
- Bubble check: during a load-use stall, confirm M_tnew chain decrements (2->1->0 as the load advances) and that the E bubble never matches D_rs.
